uart_fifo_loopback: RTL and testbench
=====================================

# uart_fifo_loopback

Parametrised UART echo engine: deserialises frames from `UART_RX`, buffers valid characters in an internal FIFO, and re-serialises them on `UART_TX` with identical framing. Generalises the board-level RX/TX loopback with configurable character width, parity mode, bit divider and FIFO depth. It adds error detection (framing, parity, overrun), a hold mode and occupancy/statistics outputs. It sits between the USB-UART pins and the board logic as the self-test path for the FTDI link.

## Interface
- `DATA_BITS`, 8, character width, 5..8
- `CLKDIV`, 100, `CLOCK` cycles per bit, >= 4
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `FIFO_DEPTH`, 16, FIFO entries, power of two >= 2
- `CLOCK`  in  1  single clock
- `RESET`  in  1  synchronous, active-high reset
- `UART_RX`  in  1  serial input, asynchronous, idle high
- `UART_TX`  out  1  serial output, idle high
- `loop_en`  in  1  1 = FIFO drains to TX; 0 = hold, TX stays idle
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `rx_count`  out  16  valid characters received, wraps 0xFFFF -> 0
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low
- `parity_err`  out  1  one-cycle pulse, parity mismatch
- `overrun`  out  1  one-cycle pulse, valid character dropped because FIFO full

## Operation
- `UART_RX` passes through a 2-flop synchroniser; all RX decisions use the synchronised value.
- RX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
  - IDLE: a 1->0 transition of the synchronised line starts the bit counter and moves to START.
  - START: sample at CLKDIV/2 cycles. If high, treat as a glitch: return to IDLE with no flag. If low, go to DATA.
  - DATA: DATA_BITS samples, each CLKDIV cycles apart, LSB first.
  - PARITY: one sample. Odd parity requires XOR(data, p) = 1; even parity requires XOR(data, p) = 0.
  - STOP: one sample. Low -> `frame_err`, character discarded. Else parity bad -> `parity_err`, character discarded. Else valid. Frame error takes priority; only one flag is raised per frame.
  - Return to IDLE in the cycle after the stop sample, so back-to-back frames are accepted. A line held low (break) raises no new start because a falling edge is required.
- Valid character: push to FIFO and increment `rx_count`. If the FIFO is full and no pop occurs that cycle, drop the character, pulse `overrun`, and still increment `rx_count`.
- Push and pop in the same cycle are both performed, `fifo_level` is unchanged, and there is no overrun even when full. Pop requires a non-empty FIFO.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
  - In IDLE with `loop_en` = 1 and FIFO non-empty: pop the head and load the shift register.
  - Start bit 0, DATA_BITS LSB first, parity bit computed per PARITY, one stop bit 1. Each bit lasts exactly CLKDIV cycles.
  - After STOP, the next pop may occur in the IDLE cycle that follows, so consecutive frames have no extra idle bit.
- `loop_en` is sampled only in TX IDLE. Deasserting it mid-frame lets the current frame complete.
- `RESET` at any point, including mid-frame: both FSMs go to IDLE, the FIFO empties, and the counters clear.

## Timing
- Reset values, in the cycle after `RESET` is sampled high: `UART_TX`=1, `fifo_level`=0, `rx_count`=0, `frame_err`=`parity_err`=`overrun`=0.
- RX sample points relative to the first synchronised-low cycle: start at +CLKDIV/2, data bit k at +CLKDIV/2+(k+1)·CLKDIV, then parity, then stop.
- A push, pulse or count update is registered in the cycle after the stop sample. `fifo_level` reflects it in that same cycle.
- TX start: `UART_TX` goes low 2 cycles after the push, if TX is idle, `loop_en`=1 and the FIFO was previously empty.
- Frame length is (1 + DATA_BITS + (PARITY?1:0) + 1)·CLKDIV cycles.
- Error pulses are exactly one cycle wide.

## Test plan
- Reset, then send 0xA5 (CLKDIV=16, PARITY=0, loop_en=1) -> `UART_TX` replays start, 1,0,1,0,0,1,0,1, stop. Each bit is 16 cycles, the start bit falls 2 cycles after the push, and `rx_count`=1.
- FIFO_DEPTH=4, loop_en=0, send 0x01..0x05 -> `fifo_level`=4 and a single `overrun` pulse on 0x05. Then set loop_en=1 -> 0x01..0x04 are echoed back-to-back, 160 cycles apart, and `fifo_level` ends at 0.
- Frame 0x3C with the stop bit driven 0 -> one `frame_err` pulse, no push, `rx_count` unchanged. The line then held low for 3 frames -> no further activity.
- PARITY=2, 0x07 with parity bit 0 -> `parity_err` and no echo. 0x07 with parity bit 1 -> echoed with parity bit 1. PARITY=1, 0x07 with parity bit 0 -> accepted.
- `UART_RX` low for 4 cycles, then high (CLKDIV=16) -> no flags, no push, RX back in IDLE and able to receive 0x55 immediately after.
- Assert `RESET` during bit 3 of the TX frame with 2 characters queued -> `UART_TX`=1 and `fifo_level`=0 the next cycle, and no further TX activity.

Source files
------------

// File: rtl/uart_fifo_loopback.sv
// UART echo engine: RX deserialiser -> character FIFO -> TX serialiser with matching framing.
// Flags framing/parity/overrun errors, supports hold mode, exposes FIFO occupancy and RX count.
module uart_fifo_loopback #(
    parameter int DATA_BITS  = 8,
    parameter int CLKDIV     = 100,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic                          UART_RX,
    output logic                          UART_TX,
    input  logic                          loop_en,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKDIV + 1);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_BIT  = CW'(CLKDIV);
    localparam logic [CW-1:0] C_HALF = CW'(CLKDIV / 2);
    localparam logic [CW-1:0] C_STOP = CW'(CLKDIV - 1);
    localparam logic [IW-1:0] C_LAST = IW'(DATA_BITS - 1);
    localparam logic [AW:0]   C_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic                 r_rx_s1, r_rx_s2, r_rx_prev;
    state_t               r_rx_state, w_rx_next;
    logic [CW-1:0]        r_rx_cnt;
    logic [IW-1:0]        r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_par;
    logic                 w_rx_sample, w_rx_stop, w_par_bad;
    logic                 w_frame, w_perr, w_rx_valid;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [AW:0]          r_level;
    logic                 w_full, w_empty, w_push, w_pop;

    logic [15:0]          r_rx_count;
    logic                 r_ferr, r_perr, r_ovr;

    state_t               r_tx_state, w_tx_next;
    logic [CW-1:0]        r_tx_cnt;
    logic [IW-1:0]        r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par, r_tx;
    logic                 w_tx_adv, w_tx_bit;

    // ---------------- RX ----------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= UART_RX;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) r_rx_state <= S_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next   = r_rx_state;
        w_rx_sample = 1'b0;
        case (r_rx_state)
            S_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_next = S_START;
            S_START: if (r_rx_cnt == C_HALF) begin
                         w_rx_sample = 1'b1;
                         w_rx_next   = r_rx_s2 ? S_IDLE : S_DATA;
                     end
            S_DATA:  if (r_rx_cnt == C_BIT) begin
                         w_rx_sample = 1'b1;
                         if (r_rx_idx == C_LAST) w_rx_next = (PARITY != 0) ? S_PAR : S_STOP;
                     end
            S_PAR:   if (r_rx_cnt == C_BIT) begin
                         w_rx_sample = 1'b1;
                         w_rx_next   = S_STOP;
                     end
            S_STOP:  if (r_rx_cnt == C_BIT) begin
                         w_rx_sample = 1'b1;
                         w_rx_next   = S_IDLE;
                     end
            default: w_rx_next = S_IDLE;
        endcase
    end

    // Odd parity wants XOR(data,p)=1, even wants 0; framing error outranks parity.
    assign w_par_bad  = (PARITY == 0) ? 1'b0 : ((^{r_rx_data, r_rx_par}) ^ (PARITY == 1));
    assign w_rx_stop  = (r_rx_state == S_STOP) && w_rx_sample;
    assign w_frame    = w_rx_stop && !r_rx_s2;
    assign w_perr     = w_rx_stop && r_rx_s2 && w_par_bad;
    assign w_rx_valid = w_rx_stop && r_rx_s2 && !w_par_bad;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_rx_cnt  <= C_ONE;
            r_rx_idx  <= '0;
            r_rx_data <= '0;
            r_rx_par  <= 1'b0;
        end else begin
            r_rx_cnt <= (r_rx_state == S_IDLE || w_rx_sample) ? C_ONE : r_rx_cnt + C_ONE;
            if (r_rx_state == S_DATA && w_rx_sample) begin
                r_rx_data <= {r_rx_s2, r_rx_data[DATA_BITS-1:1]};
                r_rx_idx  <= r_rx_idx + IW'(1);
            end else if (r_rx_state != S_DATA) begin
                r_rx_idx  <= '0;
            end
            if (r_rx_state == S_PAR && w_rx_sample) r_rx_par <= r_rx_s2;
        end
    end

    // ---------------- FIFO and statistics ----------------
    assign w_full  = (r_level == C_FULL);
    assign w_empty = (r_level == '0);
    assign w_push  = w_rx_valid && (!w_full || w_pop);

    always_ff @(posedge CLOCK) begin
        if (w_push) r_mem[r_wptr] <= r_rx_data;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_rx_count <= '0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_level    <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_rx_count <= r_rx_count + 16'(w_rx_valid);
            r_ferr     <= w_frame;
            r_perr     <= w_perr;
            r_ovr      <= w_rx_valid && w_full && !w_pop;
        end
    end

    // ---------------- TX ----------------
    always_ff @(posedge CLOCK) begin
        if (RESET) r_tx_state <= S_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    // STOP runs one cycle short: the IDLE (pop) cycle supplies its last cycle.
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_adv  = 1'b0;
        w_pop     = 1'b0;
        w_tx_bit  = 1'b1;
        case (r_tx_state)
            S_IDLE:  if (loop_en && !w_empty) begin
                         w_pop     = 1'b1;
                         w_tx_next = S_START;
                     end
            S_START: begin
                         w_tx_bit = 1'b0;
                         if (r_tx_cnt == C_BIT) begin
                             w_tx_adv  = 1'b1;
                             w_tx_next = S_DATA;
                         end
                     end
            S_DATA:  begin
                         w_tx_bit = r_tx_shift[0];
                         if (r_tx_cnt == C_BIT) begin
                             w_tx_adv = 1'b1;
                             if (r_tx_idx == C_LAST) w_tx_next = (PARITY != 0) ? S_PAR : S_STOP;
                         end
                     end
            S_PAR:   begin
                         w_tx_bit = r_tx_par;
                         if (r_tx_cnt == C_BIT) begin
                             w_tx_adv  = 1'b1;
                             w_tx_next = S_STOP;
                         end
                     end
            S_STOP:  if (r_tx_cnt == C_STOP) begin
                         w_tx_adv  = 1'b1;
                         w_tx_next = S_IDLE;
                     end
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_tx_cnt   <= C_ONE;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx     <= w_tx_bit;
            r_tx_cnt <= (r_tx_state == S_IDLE || w_tx_adv) ? C_ONE : r_tx_cnt + C_ONE;
            if (w_pop) begin
                r_tx_shift <= r_mem[r_rptr];
                r_tx_par   <= (^r_mem[r_rptr]) ^ (PARITY == 1);
                r_tx_idx   <= '0;
            end else if (r_tx_state == S_DATA && w_tx_adv) begin
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_idx   <= r_tx_idx + IW'(1);
            end
        end
    end

    assign UART_TX    = r_tx;
    assign fifo_level = r_level;
    assign rx_count   = r_rx_count;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_fifo_loopback.sv
// Bench for uart_fifo_loopback: one no-parity DUT (depth 4) plus even/odd parity DUTs on a shared line.
module tb_uart_fifo_loopback;
    localparam int DIV = 16;

    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, loop = 1'b0, prx = 1'b1, ploop = 1'b1;
    logic tx, ferr, perr, ovr;
    logic [2:0] lvl;
    logic [15:0] cnt;
    logic e_tx, e_ferr, e_perr, e_ovr, o_tx, o_ferr, o_perr, o_ovr;
    logic [2:0] e_lvl, o_lvl;
    logic [15:0] e_cnt, o_cnt;

    int total = 0, bad = 0, cyc = 0, rd = 0;
    int n_ferr = 0, n_perr = 0, n_ovr = 0, ne_perr = 0, no_perr = 0, e_low = 0;
    logic [7:0] got[$];
    int got_t[$];

    always #5 clk = ~clk;

    uart_fifo_loopback #(.DATA_BITS(8), .CLKDIV(DIV), .PARITY(0), .FIFO_DEPTH(4)) dut (
        .CLOCK(clk), .RESET(rst), .UART_RX(rx), .UART_TX(tx), .loop_en(loop),
        .fifo_level(lvl), .rx_count(cnt), .frame_err(ferr), .parity_err(perr), .overrun(ovr));
    uart_fifo_loopback #(.DATA_BITS(8), .CLKDIV(DIV), .PARITY(2), .FIFO_DEPTH(4)) dut_e (
        .CLOCK(clk), .RESET(rst), .UART_RX(prx), .UART_TX(e_tx), .loop_en(ploop),
        .fifo_level(e_lvl), .rx_count(e_cnt), .frame_err(e_ferr), .parity_err(e_perr), .overrun(e_ovr));
    uart_fifo_loopback #(.DATA_BITS(8), .CLKDIV(DIV), .PARITY(1), .FIFO_DEPTH(4)) dut_o (
        .CLOCK(clk), .RESET(rst), .UART_RX(prx), .UART_TX(o_tx), .loop_en(ploop),
        .fifo_level(o_lvl), .rx_count(o_cnt), .frame_err(o_ferr), .parity_err(o_perr), .overrun(o_ovr));

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters: a one-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (ferr === 1'b1)   n_ferr  <= n_ferr + 1;
        if (perr === 1'b1)   n_perr  <= n_perr + 1;
        if (ovr === 1'b1)    n_ovr   <= n_ovr + 1;
        if (e_perr === 1'b1) ne_perr <= ne_perr + 1;
        if (o_perr === 1'b1) no_perr <= no_perr + 1;
        if (e_tx === 1'b0)   e_low   <= e_low + 1;
    end

    // Independent decoder of the main TX line, mid-bit sampling.
    initial begin
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                t0 = cyc;
                repeat (DIV/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                got.push_back(b);
                got_t.push_back(t0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic p,
                              input logic stop, input bit to_p);
        logic [10:0] bits;
        int n;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (par_en) begin bits[9] = p; bits[10] = stop; n = 11; end
        else begin bits[9] = stop; bits[10] = 1'b1; n = 10; end
        for (int i = 0; i < n; i++) begin
            if (to_p) prx = bits[i];
            else      rx  = bits[i];
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic wait_echo(input string name, input int need, input int limit);
        int k = 0;
        while (got.size() - rd < need && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (k >= limit) chk(name, got.size() - rd, need);
    endtask

    task automatic observe_a5();
        int k = 0, errs;
        logic [9:0] eb;
        eb = {1'b1, 8'hA5, 1'b0};
        while (lvl !== 3'd1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("a5_push_seen", lvl, 1);
        @(negedge clk);
        chk("a5_tx_high_1_after_push", tx, 1);
        for (int j = 0; j < 10; j++) begin
            errs = 0;
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                if (tx !== eb[j]) errs++;
            end
            chk($sformatf("a5_bit%0d_bad_cycles", j), errs, 0);
        end
    endtask

    task automatic capture_e(output logic [10:0] cap);
        int k = 0;
        while (e_tx !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (DIV/2) @(negedge clk);
        cap[0] = e_tx;
        for (int i = 1; i < 11; i++) begin
            repeat (DIV) @(negedge clk);
            cap[i] = e_tx;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         ferr_inc;
        int         cnt_inc;
        int         echo;
    } vec_t;

    initial begin
        vec_t tbl[6];
        logic [7:0] exp_q[$];
        logic [7:0] d;
        logic [10:0] cap;
        logic [15:0] base_c;
        int base_f, base_o, base_ep, base_op, base_el, gap, n_echo, lows;
        bit bs;

        tbl[0] = '{8'h00, 1'b1, 0, 1, 1};
        tbl[1] = '{8'hFF, 1'b1, 0, 1, 1};
        tbl[2] = '{8'h80, 1'b1, 0, 1, 1};
        tbl[3] = '{8'h3C, 1'b0, 1, 0, 0};
        tbl[4] = '{8'h5A, 1'b1, 0, 1, 1};
        tbl[5] = '{8'h81, 1'b0, 1, 0, 0};

        // Reset values
        @(negedge clk); @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_level", lvl, 0);
        chk("rst_count", cnt, 0);
        chk("rst_flags", {ferr, perr, ovr}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 0xA5 with exact TX timing
        loop = 1'b1;
        fork
            send_frame(8'hA5, 0, 1'b0, 1'b1, 0);
            observe_a5();
        join
        wait_echo("a5_echo_timeout", 1, 300);
        chk("a5_echo", got[rd], 8'hA5);
        rd++;
        chk("a5_count", cnt, 1);
        repeat (50) @(negedge clk);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            base_f = n_ferr;
            base_c = cnt;
            send_frame(tbl[i].d, 0, 1'b0, tbl[i].stop, 0);
            rx = 1'b1;
            repeat (300) @(negedge clk);
            n_echo = got.size() - rd;
            chk($sformatf("tbl%0d_ferr", i), n_ferr - base_f, tbl[i].ferr_inc);
            chk($sformatf("tbl%0d_count", i), 16'(cnt - base_c), tbl[i].cnt_inc);
            chk($sformatf("tbl%0d_echoes", i), n_echo, tbl[i].echo);
            if (n_echo > 0) chk($sformatf("tbl%0d_data", i), got[rd], tbl[i].d);
            rd += n_echo;
        end

        // Bad stop then line held low (break)
        base_f = n_ferr;
        base_c = cnt;
        send_frame(8'h3C, 0, 1'b0, 1'b0, 0);
        repeat (3 * 10 * DIV) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        chk("brk_ferr", n_ferr - base_f, 1);
        chk("brk_count", cnt, base_c);
        chk("brk_level", lvl, 0);
        chk("brk_echoes", got.size() - rd, 0);

        // Short low glitch, then a real frame
        base_f = n_ferr;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("glitch_flags", (n_ferr - base_f) + n_perr + n_ovr, 0);
        chk("glitch_level", lvl, 0);
        chk("glitch_count", cnt, base_c);
        send_frame(8'h55, 0, 1'b0, 1'b1, 0);
        wait_echo("glitch_echo_timeout", 1, 400);
        chk("glitch_echo", got[rd], 8'h55);
        rd++;
        chk("glitch_count_after", 16'(cnt - base_c), 1);

        // Overrun in hold mode, then drain back-to-back
        repeat (50) @(negedge clk);
        loop = 1'b0;
        base_o = n_ovr;
        base_c = cnt;
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 0, 1'b0, 1'b1, 0);
            if (v == 4) begin
                chk("ovr_level_at4", lvl, 4);
                chk("ovr_none_at4", n_ovr - base_o, 0);
            end
        end
        repeat (4) @(negedge clk);
        chk("ovr_level_full", lvl, 4);
        chk("ovr_pulses", n_ovr - base_o, 1);
        chk("ovr_count", 16'(cnt - base_c), 5);
        loop = 1'b1;
        wait_echo("drain_timeout", 4, 1000);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_data%0d", i), got[rd+i], i + 1);
            if (i > 0) chk($sformatf("drain_gap%0d", i), got_t[rd+i] - got_t[rd+i-1], 10 * DIV);
        end
        rd += 4;
        chk("drain_level", lvl, 0);
        repeat (50) @(negedge clk);

        // Randomised traffic against a queue model
        base_f = n_ferr;
        base_c = cnt;
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom_range(0, 255));
            bs = ($urandom_range(0, 4) == 0);
            send_frame(d, 0, 1'b0, !bs, 0);
            if (!bs) exp_q.push_back(d);
            gap = bs ? $urandom_range(2, 20) : $urandom_range(0, 20);
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
        wait_echo("rand_timeout", exp_q.size(), 3000);
        for (int i = 0; i < exp_q.size(); i++)
            if (rd + i < got.size()) chk($sformatf("rand_echo%0d", i), got[rd+i], exp_q[i]);
        chk("rand_count", 16'(cnt - base_c), exp_q.size());
        chk("rand_ferr", n_ferr - base_f, 24 - exp_q.size());
        rd += exp_q.size();
        repeat (50) @(negedge clk);

        // Reset during TX data bit 3 with two characters still queued
        loop = 1'b0;
        send_frame(8'hA1, 0, 1'b0, 1'b1, 0);
        send_frame(8'hB2, 0, 1'b0, 1'b1, 0);
        send_frame(8'hC3, 0, 1'b0, 1'b1, 0);
        repeat (4) @(negedge clk);
        chk("rstmid_level_before", lvl, 3);
        loop = 1'b1;
        lows = 0;
        while (tx !== 1'b0 && lows < 50) begin
            @(negedge clk);
            lows++;
        end
        repeat (DIV + 3 * DIV + DIV/2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_tx", tx, 1);
        chk("rstmid_level", lvl, 0);
        chk("rstmid_count", cnt, 0);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || lvl !== 3'd0) lows++;
        end
        chk("rstmid_quiet_cycles", lows, 0);
        rd = got.size();

        // Parity: 0x07 with p=0 then p=1 into even and odd receivers
        base_ep = ne_perr;
        base_op = no_perr;
        base_el = e_low;
        send_frame(8'h07, 1, 1'b0, 1'b1, 1);
        repeat (300) @(negedge clk);
        chk("par_even_err", ne_perr - base_ep, 1);
        chk("par_odd_ok", no_perr - base_op, 0);
        chk("par_even_count", e_cnt, 0);
        chk("par_odd_count", o_cnt, 1);
        chk("par_even_no_echo", e_low - base_el, 0);
        fork
            send_frame(8'h07, 1, 1'b1, 1'b1, 1);
            capture_e(cap);
        join
        chk("par_even_echo_frame", cap, {1'b1, 1'b1, 8'h07, 1'b0});
        chk("par_even_err_after", ne_perr - base_ep, 1);
        chk("par_odd_err", no_perr - base_op, 1);
        chk("par_even_count_after", e_cnt, 1);
        chk("par_odd_count_after", o_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
